// File: rtl/tlc_plan_scheduler.sv
// Time-of-day plan scheduler: BCD 24 h clock, peak/pm flags and a phase-duration
// plan handed to the sequencer over valid/ack, only at a light-cycle boundary.
module tlc_plan_scheduler #(
  parameter int         TICKS_PER_SEC  = 1,
  parameter logic [7:0] AM_PEAK_START  = 8'h08,
  parameter logic [7:0] AM_PEAK_END    = 8'h10,
  parameter logic [7:0] PM_PEAK_START  = 8'h17,
  parameter logic [7:0] PM_PEAK_END    = 8'h19,
  parameter logic [7:0] GREEN_NORMAL   = 8'd20,
  parameter logic [7:0] GREEN_PEAK     = 8'd40,
  parameter logic [7:0] GREEN_SIDE     = 8'd15,
  parameter logic [7:0] GREEN_SIDE_MIN = 8'd5,
  parameter logic [7:0] YELLOW_LEN     = 8'd3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ena_i,
  input  logic       set_time_i,
  input  logic [7:0] set_hh_i,
  input  logic [7:0] set_mm_i,
  input  logic [7:0] set_ss_i,
  input  logic       sensor1_i,
  input  logic       sensor2_i,
  input  logic       cycle_done_i,
  input  logic       plan_ack_i,
  output logic       plan_valid_o,
  output logic [7:0] green_main_o,
  output logic [7:0] green_side_o,
  output logic [7:0] yellow_len_o,
  output logic       peak_o,
  output logic       pm_o,
  output logic [7:0] hh_o,
  output logic [7:0] mm_o,
  output logic [7:0] ss_o,
  output logic       sec_tick_o
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    WAIT_BOUNDARY = 2'd1,
    OFFER         = 2'd2
  } state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic          sec_tick_q, sec_tick_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic          peak_q, peak_d, pm_q, pm_d;
  logic          side_q, side_d;
  state_e        state_q, state_d;
  logic [7:0]    act_gm_q, act_gm_d, act_gs_q, act_gs_d, act_y_q, act_y_d;
  logic [7:0]    off_gm_q, off_gm_d, off_gs_q, off_gs_d, off_y_q, off_y_d;

  logic          set_ok;
  logic          accept;
  logic [7:0]    gm_t, gs_t, y_t;
  logic          target_differs;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // A malformed load is dropped as a whole, prescaler clear included.
  assign set_ok = set_time_i &&
                  (set_ss_i[3:0] <= 4'd9) && (set_ss_i <= 8'h59) &&
                  (set_mm_i[3:0] <= 4'd9) && (set_mm_i <= 8'h59) &&
                  (set_hh_i[3:0] <= 4'd9) && (set_hh_i <= 8'h23);

  always_comb begin
    presc_d    = presc_q;
    sec_tick_d = 1'b0;
    if (set_ok) begin
      presc_d = '0;
    end else if (ena_i) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
    if (ena_i && (presc_q == PRESC_LAST)) sec_tick_d = 1'b1;
  end

  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (set_ok) begin
      hh_d = set_hh_i;
      mm_d = set_mm_i;
      ss_d = set_ss_i;
    end else if (sec_tick_q) begin
      if (ss_q == 8'h59) begin
        ss_d = 8'h00;
        if (mm_q == 8'h59) begin
          mm_d = 8'h00;
          hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
        end else begin
          mm_d = bcd_inc(mm_q);
        end
      end else begin
        ss_d = bcd_inc(ss_q);
      end
    end
  end

  // Packed BCD orders the same as binary, so plain compares are valid.
  always_comb begin
    peak_d = ((hh_q >= AM_PEAK_START) && (hh_q < AM_PEAK_END)) ||
             ((hh_q >= PM_PEAK_START) && (hh_q < PM_PEAK_END));
    pm_d   = (hh_q >= 8'h12);
  end

  always_comb begin
    gm_t           = peak_q ? GREEN_PEAK : GREEN_NORMAL;
    gs_t           = side_q ? GREEN_SIDE : GREEN_SIDE_MIN;
    y_t            = YELLOW_LEN;
    target_differs = (gm_t != act_gm_q) || (gs_t != act_gs_q) || (y_t != act_y_q);
  end

  always_comb begin
    state_d  = state_q;
    act_gm_d = act_gm_q;
    act_gs_d = act_gs_q;
    act_y_d  = act_y_q;
    off_gm_d = off_gm_q;
    off_gs_d = off_gs_q;
    off_y_d  = off_y_q;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (target_differs) state_d = WAIT_BOUNDARY;
      end
      WAIT_BOUNDARY: begin
        if (!target_differs) begin
          state_d = IDLE;
        end else if (cycle_done_i) begin
          off_gm_d = gm_t;
          off_gs_d = gs_t;
          off_y_d  = y_t;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (plan_ack_i) begin
          act_gm_d = off_gm_q;
          act_gs_d = off_gs_q;
          act_y_d  = off_y_q;
          accept   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A sensor hit in the accept cycle belongs to the next plan, so it wins.
  assign side_d = sensor1_i | sensor2_i | (side_q & ~accept);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      peak_q     <= 1'b0;
      pm_q       <= 1'b0;
      side_q     <= 1'b0;
      state_q    <= IDLE;
      act_gm_q   <= GREEN_NORMAL;
      act_gs_q   <= GREEN_SIDE_MIN;
      act_y_q    <= YELLOW_LEN;
      off_gm_q   <= GREEN_NORMAL;
      off_gs_q   <= GREEN_SIDE_MIN;
      off_y_q    <= YELLOW_LEN;
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      peak_q     <= peak_d;
      pm_q       <= pm_d;
      side_q     <= side_d;
      state_q    <= state_d;
      act_gm_q   <= act_gm_d;
      act_gs_q   <= act_gs_d;
      act_y_q    <= act_y_d;
      off_gm_q   <= off_gm_d;
      off_gs_q   <= off_gs_d;
      off_y_q    <= off_y_d;
    end
  end

  assign plan_valid_o = (state_q == OFFER);
  assign green_main_o = plan_valid_o ? off_gm_q : act_gm_q;
  assign green_side_o = plan_valid_o ? off_gs_q : act_gs_q;
  assign yellow_len_o = plan_valid_o ? off_y_q  : act_y_q;
  assign peak_o       = peak_q;
  assign pm_o         = pm_q;
  assign hh_o         = hh_q;
  assign mm_o         = mm_q;
  assign ss_o         = ss_q;
  assign sec_tick_o   = sec_tick_q;

endmodule

// File: tb/tb_tlc_plan_scheduler.sv
// Bench for tlc_plan_scheduler: decimal time model checked every cycle, offered
// plans checked against a queue of expectations pushed with each cycle_done.
module tb_tlc_plan_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ena_i, set_time_i, sensor1_i, sensor2_i, cycle_done_i, plan_ack_i;
  logic [7:0] set_hh_i, set_mm_i, set_ss_i;
  logic       plan_valid_o, peak_o, pm_o, sec_tick_o;
  logic [7:0] green_main_o, green_side_o, yellow_len_o, hh_o, mm_o, ss_o;

  int checks   = 0;
  int failures = 0;

  int m_h, m_m, m_s;
  bit m_tick, m_peak, m_pm;
  bit pv_prev;
  logic [23:0] exp_q[$];

  tlc_plan_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .set_time_i(set_time_i),
    .set_hh_i(set_hh_i), .set_mm_i(set_mm_i), .set_ss_i(set_ss_i),
    .sensor1_i(sensor1_i), .sensor2_i(sensor2_i), .cycle_done_i(cycle_done_i),
    .plan_ack_i(plan_ack_i), .plan_valid_o(plan_valid_o),
    .green_main_o(green_main_o), .green_side_o(green_side_o),
    .yellow_len_o(yellow_len_o), .peak_o(peak_o), .pm_o(pm_o),
    .hh_o(hh_o), .mm_o(mm_o), .ss_o(ss_o), .sec_tick_o(sec_tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input int maxv);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (from_bcd(v) <= maxv);
  endfunction

  function automatic bit is_peak(input int h);
    return ((h >= 8) && (h < 10)) || ((h >= 17) && (h < 19));
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0;
    m_tick = 0; m_peak = 0; m_pm = 0;
    pv_prev = 0;
  endtask

  // One clock: advance the reference model with the inputs seen at the edge,
  // then compare time outputs and pop an expectation on each new offer.
  task automatic step();
    bit         c_rst, c_ena, c_set;
    logic [7:0] c_h, c_m, c_s;
    logic [23:0] e;
    c_rst = rst_ni; c_ena = ena_i; c_set = set_time_i;
    c_h = set_hh_i; c_m = set_mm_i; c_s = set_ss_i;
    @(posedge clk_i);
    #1;
    if (!c_rst) begin
      model_reset();
    end else begin
      m_peak = is_peak(m_h);
      m_pm   = (m_h >= 12);
      if (c_set && bcd_ok(c_h, 23) && bcd_ok(c_m, 59) && bcd_ok(c_s, 59)) begin
        m_h = from_bcd(c_h); m_m = from_bcd(c_m); m_s = from_bcd(c_s);
      end else if (m_tick) begin
        m_s++;
        if (m_s == 60) begin m_s = 0; m_m++; end
        if (m_m == 60) begin m_m = 0; m_h++; end
        if (m_h == 24) m_h = 0;
      end
      m_tick = c_ena;
    end
    check_eq("hh", hh_o, to_bcd(m_h));
    check_eq("mm", mm_o, to_bcd(m_m));
    check_eq("ss", ss_o, to_bcd(m_s));
    check_eq("sec_tick", sec_tick_o, m_tick);
    check_eq("peak", peak_o, m_peak);
    check_eq("pm", pm_o, m_pm);
    if (plan_valid_o && !pv_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_offer", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("offer_green_main", green_main_o, e[23:16]);
        check_eq("offer_green_side", green_side_o, e[15:8]);
        check_eq("offer_yellow", yellow_len_o, e[7:0]);
        $display("offer main=%0d side=%0d yellow=%0d", green_main_o, green_side_o, yellow_len_o);
      end
    end
    pv_prev = plan_valid_o;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh_i = h; set_mm_i = m; set_ss_i = s; set_time_i = 1'b1;
    step();
    set_time_i = 1'b0;
  endtask

  task automatic boundary(input logic [7:0] gm, input logic [7:0] gs);
    exp_q.push_back({gm, gs, 8'd3});
    cycle_done_i = 1'b1;
    step();
    cycle_done_i = 1'b0;
    check_eq("offer_valid", plan_valid_o, 1);
  endtask

  task automatic ack(input bit sensor);
    plan_ack_i = 1'b1; sensor2_i = sensor;
    step();
    plan_ack_i = 1'b0; sensor2_i = 1'b0;
    check_eq("ack_valid_low", plan_valid_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; ena_i = 1'b0; set_time_i = 1'b0;
    set_hh_i = 8'h00; set_mm_i = 8'h00; set_ss_i = 8'h00;
    sensor1_i = 1'b0; sensor2_i = 1'b0; cycle_done_i = 1'b0; plan_ack_i = 1'b0;
    model_reset();
    steps(3);
    check_eq("rst_plan_valid", plan_valid_o, 0);
    check_eq("rst_green_main", green_main_o, 20);
    check_eq("rst_green_side", green_side_o, 5);
    check_eq("rst_yellow", yellow_len_o, 3);

    rst_ni = 1'b1; ena_i = 1'b1;
    steps(200);
    ena_i = 1'b0;
    steps(4);
    ena_i = 1'b1;

    // Every hour rollover, including 23:59:59 -> 00:00:00 and peak edges.
    for (int h = 0; h < 24; h++) begin
      load_time(to_bcd(h), 8'h59, 8'h55);
      steps(8);
    end
    check_eq("no_offer_queue", exp_q.size(), 0);

    load_time(8'h07, 8'h59, 8'h59);
    steps(4);
    check_eq("peak_0800", peak_o, 1);
    plan_ack_i = 1'b1;
    boundary(8'd40, 8'd5);
    plan_ack_i = 1'b0;
    step();
    check_eq("ack_ignored_with_done", plan_valid_o, 1);
    ack(1'b0);
    check_eq("active_main_40", green_main_o, 40);

    sensor1_i = 1'b1; step(); sensor1_i = 1'b0;
    steps(2);
    boundary(8'd40, 8'd15);
    ack(1'b0);
    steps(2);
    boundary(8'd40, 8'd5);

    load_time(8'h09, 8'h59, 8'h58);
    for (int i = 0; i < 6; i++) begin
      sensor2_i = (i == 2);
      step();
      check_eq("hold_valid", plan_valid_o, 1);
      check_eq("hold_main", green_main_o, 40);
      check_eq("hold_side", green_side_o, 5);
    end
    check_eq("peak_after_10", peak_o, 0);
    ack(1'b1);
    check_eq("active_side_5", green_side_o, 5);
    steps(2);
    boundary(8'd20, 8'd15);
    ack(1'b0);
    steps(2);
    boundary(8'd20, 8'd5);
    ack(1'b0);
    steps(2);
    cycle_done_i = 1'b1; step(); cycle_done_i = 1'b0;
    steps(2);
    check_eq("done_idle_ignored", plan_valid_o, 0);
    plan_ack_i = 1'b1; step(); plan_ack_i = 1'b0;
    check_eq("ack_idle_ignored", plan_valid_o, 0);

    load_time(8'h10, 8'h60, 8'h00);
    load_time(8'h10, 8'h30, 8'h5A);
    load_time(8'h24, 8'h00, 8'h00);
    load_time(8'h12, 8'h34, 8'h56);
    check_eq("load_ss", ss_o, 8'h56);
    steps(3);

    load_time(8'h17, 8'h00, 8'h00);
    steps(4);
    boundary(8'd40, 8'd5);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("async_valid", plan_valid_o, 0);
    check_eq("async_hh", hh_o, 8'h00);
    check_eq("async_ss", ss_o, 8'h00);
    check_eq("async_main", green_main_o, 20);
    model_reset();
    steps(2);
    rst_ni = 1'b1;
    steps(5);
    check_eq("post_rst_main", green_main_o, 20);
    check_eq("post_rst_valid", plan_valid_o, 0);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
